// File: rtl/matrix_stream_loader_if.sv
// Dibit symbol stream in, row-write bus out, for matrix_stream_loader.
interface matrix_stream_loader_if #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 32,
  parameter int NUM_MAT = 2
);
  localparam int SEL_W  = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1;
  localparam int ADDR_W = $clog2(MAX_DIM);
  localparam int DATA_W = MAX_DIM * ELEM_W;

  // axiiv qualifies axiid on every rising edge and there is no backpressure:
  // each valid cycle carries exactly one symbol. wr_en qualifies wr_sel,
  // wr_addr and wr_data for that single cycle; the row BRAMs always accept.
  logic              axiiv;
  logic [1:0]        axiid;
  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output axiiv, axiid, input wr_en, wr_sel, wr_addr, wr_data);
  modport slave  (input axiiv, axiid, output wr_en, wr_sel, wr_addr, wr_data);
endinterface

// File: rtl/matrix_stream_loader.sv
// Parses a framed dibit stream into row-wide BRAM writes for NUM_MAT matrices.
// Optional trailing checksum is compiled in with MATRIX_STREAM_LOADER_CHECK_EN.
module matrix_stream_loader #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 32,
  parameter int NUM_MAT = 2
) (
  input  logic                 eth_refclk,
  input  logic                 rst,
  matrix_stream_loader_if.slave bus,
  output logic [7:0]           dim_rows,
  output logic [7:0]           dim_cols,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic [2:0]           dbg_state
);
  localparam int SEL_W  = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1;
  localparam int ADDR_W = $clog2(MAX_DIM);
  localparam int DATA_W = MAX_DIM * ELEM_W;
  localparam int SPE    = ELEM_W / 2;
  localparam int SYM_W  = (SPE > 1) ? $clog2(SPE) : 1;

  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SPE - 1);
  localparam logic [SEL_W-1:0] MAT_LAST = SEL_W'(NUM_MAT - 1);
  localparam logic [8:0]       MAX_DIM9 = 9'(MAX_DIM);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_IDLE = 3'd1,
    S_HDR  = 3'd2,
    S_LOAD = 3'd3
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
    , S_CHK = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [13:0]         hdr_q, hdr_d;
  logic [2:0]          hcnt_q, hcnt_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [SYM_W-1:0]    sym_q, sym_d;
  logic [7:0]          col_q, col_d;
  logic [7:0]          row_q, row_d;
  logic [SEL_W-1:0]    mat_q, mat_d;
  logic [DATA_W-1:0]   row_buf_q, row_buf_d;
  logic                wr_en_q, wr_en_d;
  logic [SEL_W-1:0]    wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [7:0]          dim_rows_q, dim_rows_d;
  logic [7:0]          dim_cols_q, dim_cols_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;
  logic [1:0]          err_code_q, err_code_d;
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
  logic [ELEM_W-1:0]   acc_q, acc_d;
`endif

  logic [15:0]         hdr_full;
  logic [ELEM_W-1:0]   elem_full;
  logic [DATA_W-1:0]   row_ins;
  logic                sym_last, col_last, row_last, mat_last, hdr_bad;

  assign hdr_full  = {hdr_q, bus.axiid};
  assign elem_full = (elem_q << 2) | ELEM_W'(bus.axiid);
  assign sym_last  = (sym_q == SYM_LAST);
  assign col_last  = (col_q == dim_cols_q - 8'd1);
  assign row_last  = (row_q == dim_rows_q - 8'd1);
  assign mat_last  = (mat_q == MAT_LAST);
  assign hdr_bad   = (hdr_full[15:8] == 8'd0) || (hdr_full[7:0] == 8'd0) ||
                     ({1'b0, hdr_full[15:8]} > MAX_DIM9) ||
                     ({1'b0, hdr_full[7:0]} > MAX_DIM9);

  // Current row buffer with the element being completed dropped into slot col_q.
  always_comb begin
    row_ins = row_buf_q;
    for (int j = 0; j < MAX_DIM; j++) begin
      if (col_q == 8'(j)) row_ins[(MAX_DIM - j) * ELEM_W - 1 -: ELEM_W] = elem_full;
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    hcnt_d       = hcnt_q;
    elem_d       = elem_q;
    sym_d        = sym_q;
    col_d        = col_q;
    row_d        = row_q;
    mat_d        = mat_q;
    row_buf_d    = row_buf_q;
    wr_en_d      = 1'b0;
    wr_sel_d     = wr_sel_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    dim_rows_d   = dim_rows_q;
    dim_cols_d   = dim_cols_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
    acc_d        = acc_q;
`endif

    case (state_q)
      S_WAIT: begin
        if (!bus.axiiv) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (bus.axiiv) begin
          hdr_d   = {12'b0, bus.axiid};
          hcnt_d  = 3'd0;
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        if (!bus.axiiv) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = S_IDLE;
        end else begin
          hdr_d  = hdr_full[13:0];
          hcnt_d = hcnt_q + 3'd1;
          if (hcnt_q == 3'd6) begin
            if (hdr_bad) begin
              frame_err_d = 1'b1;
              err_code_d  = 2'd1;
              state_d     = S_WAIT;
            end else begin
              dim_rows_d = hdr_full[15:8];
              dim_cols_d = hdr_full[7:0];
              elem_d     = '0;
              sym_d      = '0;
              col_d      = 8'd0;
              row_d      = 8'd0;
              mat_d      = '0;
              row_buf_d  = '0;
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
              acc_d      = '0;
`endif
              state_d    = S_LOAD;
            end
          end
        end
      end

      S_LOAD: begin
        if (!bus.axiiv) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = S_IDLE;
        end else begin
          elem_d = elem_full;
          sym_d  = sym_q + SYM_W'(1);
          if (sym_last) begin
            sym_d     = '0;
            row_buf_d = row_ins;
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
            acc_d     = acc_q + elem_full;
`endif
            if (col_last) begin
              // Row complete: write it out and start the next row from zero.
              wr_en_d   = 1'b1;
              wr_sel_d  = mat_q;
              wr_addr_d = row_q[ADDR_W-1:0];
              wr_data_d = row_ins;
              row_buf_d = '0;
              col_d     = 8'd0;
              if (row_last) begin
                row_d = 8'd0;
                if (mat_last) begin
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
                  state_d = S_CHK;
`else
                  frame_done_d = 1'b1;
                  err_code_d   = 2'd0;
                  state_d      = S_WAIT;
`endif
                end else begin
                  mat_d = mat_q + SEL_W'(1);
                end
              end else begin
                row_d = row_q + 8'd1;
              end
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end
      end

`ifdef MATRIX_STREAM_LOADER_CHECK_EN
      S_CHK: begin
        if (!bus.axiiv) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
          state_d     = S_IDLE;
        end else begin
          elem_d = elem_full;
          sym_d  = sym_q + SYM_W'(1);
          if (sym_last) begin
            sym_d   = '0;
            state_d = S_WAIT;
            if (elem_full == acc_q) begin
              frame_done_d = 1'b1;
              err_code_d   = 2'd0;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = 2'd3;
            end
          end
        end
      end
`endif

      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge eth_refclk) begin
    if (rst) begin
      state_q      <= S_WAIT;
      hdr_q        <= '0;
      hcnt_q       <= '0;
      elem_q       <= '0;
      sym_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      mat_q        <= '0;
      row_buf_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      dim_rows_q   <= '0;
      dim_cols_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
      acc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      hcnt_q       <= hcnt_d;
      elem_q       <= elem_d;
      sym_q        <= sym_d;
      col_q        <= col_d;
      row_q        <= row_d;
      mat_q        <= mat_d;
      row_buf_q    <= row_buf_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      dim_rows_q   <= dim_rows_d;
      dim_cols_q   <= dim_cols_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
      acc_q        <= acc_d;
`endif
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_sel  = wr_sel_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign dim_rows    = dim_rows_q;
  assign dim_cols    = dim_cols_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign dbg_state   = state_q;
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
  assign busy = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
`else
  assign busy = (state_q == S_HDR) || (state_q == S_LOAD);
`endif
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader (ELEM_W=8, MAX_DIM=32, NUM_MAT=2);
// adapts to builds with or without MATRIX_STREAM_LOADER_CHECK_EN.
module tb_matrix_stream_loader;
  localparam int EW  = 8;
  localparam int MD  = 32;
  localparam int NM  = 2;
  localparam int SW  = 1;
  localparam int AW  = 5;
  localparam int DW  = MD * EW;
  localparam int WW  = SW + AW + DW;
  localparam int SPE = EW / 2;
`ifdef MATRIX_STREAM_LOADER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       eth_refclk = 1'b0;
  logic       rst;
  logic [7:0] dim_rows, dim_cols;
  logic       busy, frame_done, frame_err;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  matrix_stream_loader_if #(.ELEM_W(EW), .MAX_DIM(MD), .NUM_MAT(NM)) bus ();

  matrix_stream_loader #(.ELEM_W(EW), .MAX_DIM(MD), .NUM_MAT(NM)) dut (
    .eth_refclk (eth_refclk),
    .rst        (rst),
    .bus        (bus),
    .dim_rows   (dim_rows),
    .dim_cols   (dim_cols),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 eth_refclk = ~eth_refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] obs_q[$];
  logic [EW-1:0] elem_mem [0:NM*MD*MD-1];

  // write / status monitor, sampled on the falling edge
  always @(negedge eth_refclk) begin
    if (bus.wr_en) obs_q.push_back({bus.wr_sel, bus.wr_addr, bus.wr_data});
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers: each symbol is sampled by the next rising edge; return 1 time unit after it
  task automatic send_sym(input logic [1:0] d);
    bus.axiiv = 1'b1;
    bus.axiid = d;
    @(posedge eth_refclk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    repeat (n) @(posedge eth_refclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 3; k >= 0; k--) send_sym(b[2*k+1 -: 2]);
  endtask

  task automatic send_elem(input logic [EW-1:0] e);
    for (int k = SPE - 1; k >= 0; k--) send_sym(e[2*k+1 -: 2]);
  endtask

  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) send_sym(2'($urandom_range(0, 3)));
  endtask

  // Sends a whole frame from elem_mem and queues the row writes it should produce.
  task automatic send_frame(input int rows, input int cols, input logic [EW-1:0] chk_delta);
    logic [EW-1:0] sum;
    logic [DW-1:0] row;
    int idx;
    sum = '0;
    idx = 0;
    send_byte(8'(rows));
    send_byte(8'(cols));
    for (int m = 0; m < NM; m++) begin
      for (int r = 0; r < rows; r++) begin
        row = '0;
        for (int c = 0; c < cols; c++) begin
          row[(MD - c) * EW - 1 -: EW] = elem_mem[idx];
          send_elem(elem_mem[idx]);
          sum = sum + elem_mem[idx];
          idx++;
        end
        exp_q.push_back({SW'(m), AW'(r), row});
      end
    end
    if (CHK) send_elem(sum + chk_delta);
  endtask

  task automatic check_writes(input string tag);
    logic [WW-1:0] o;
    chk({tag, "_count"}, WW'(obs_q.size()), WW'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else o = 'x;
      chk(tag, o, exp_q.pop_front());
    end
    obs_q.delete();
  endtask

  initial begin
    int d0;
    // reset
    rst = 1'b1;
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    repeat (3) @(posedge eth_refclk);
    #1;
    chk("rst_state", WW'(dbg_state), WW'(3'd0));
    chk("rst_outs", WW'({bus.wr_en, frame_done, frame_err, busy, err_code, dim_rows, dim_cols}), '0);
    chk("rst_wr_data", WW'(bus.wr_data), '0);
    rst = 1'b0;
    idle(2);

    // 1: 2x3 frame, elements 0x01..0x0C, checksum 0x4E
    for (int i = 0; i < 12; i++) elem_mem[i] = 8'(i + 1);
    send_frame(2, 3, 8'd0);
    chk("t1_done", WW'(frame_done), WW'(1'b1));
    chk("t1_err", WW'(frame_err), WW'(1'b0));
    chk("t1_code", WW'(err_code), WW'(2'd0));
    chk("t1_last_wr_with_done", WW'(bus.wr_en), WW'(!CHK));
    idle(2);
    chk("t1_dim_rows", WW'(dim_rows), WW'(8'd2));
    chk("t1_dim_cols", WW'(dim_cols), WW'(8'd3));
    chk("t1_row0_hand", (obs_q.size() > 0) ? obs_q[0] : 'x, {1'b0, 5'd0, 24'h010203, {(DW-24){1'b0}}});
    chk("t1_row3_hand", (obs_q.size() > 3) ? obs_q[3] : 'x, {1'b1, 5'd1, 24'h0A0B0C, {(DW-24){1'b0}}});
    check_writes("t1_wr");
    chk("t1_done_cnt", WW'(done_cnt), WW'(1));

    // 2: same frame, checksum 0x4F
    send_frame(2, 3, 8'd1);
    chk("t2_done", WW'(frame_done), WW'(!CHK));
    chk("t2_err", WW'(frame_err), WW'(CHK));
    chk("t2_code", WW'(err_code), WW'(CHK ? 2'd3 : 2'd0));
    idle(2);
    check_writes("t2_wr");
    chk("t2_done_cnt", WW'(done_cnt), WW'(CHK ? 1 : 2));
    chk("t2_err_cnt", WW'(err_cnt), WW'(CHK ? 1 : 0));

    // 3: bad headers rows=0 then cols=33, then a good frame
    send_byte(8'd0);
    send_byte(8'd3);
    chk("t3a_err", WW'(frame_err), WW'(1'b1));
    chk("t3a_code", WW'(err_code), WW'(2'd1));
    chk("t3a_state", WW'(dbg_state), WW'(3'd0));
    send_junk(24);
    idle(2);
    check_writes("t3a_nowr");
    chk("t3a_dims", WW'({dim_rows, dim_cols}), WW'({8'd2, 8'd3}));
    send_byte(8'd2);
    send_byte(8'd33);
    chk("t3b_err", WW'(frame_err), WW'(1'b1));
    chk("t3b_code", WW'(err_code), WW'(2'd1));
    send_junk(24);
    idle(2);
    check_writes("t3b_nowr");
    chk("t3b_dims", WW'({dim_rows, dim_cols}), WW'({8'd2, 8'd3}));
    for (int i = 0; i < 12; i++) elem_mem[i] = 8'(8'h10 + i);
    send_frame(3, 2, 8'd0);
    chk("t3c_done", WW'(frame_done), WW'(1'b1));
    chk("t3c_code", WW'(err_code), WW'(2'd0));
    idle(2);
    check_writes("t3c_wr");
    chk("t3c_dims", WW'({dim_rows, dim_cols}), WW'({8'd3, 8'd2}));

    // 4: truncation mid row 1 of matrix 0, then a back-to-back frame
    send_byte(8'd2);
    send_byte(8'd3);
    send_elem(8'hA1);
    send_elem(8'hA2);
    send_elem(8'hA3);
    send_elem(8'hA4);
    send_sym(2'b10);
    send_sym(2'b11);
    exp_q.push_back({1'b0, 5'd0, 24'hA1A2A3, {(DW-24){1'b0}}});
    bus.axiiv = 1'b0;
    @(posedge eth_refclk);
    #1;
    chk("t4_err", WW'(frame_err), WW'(1'b1));
    chk("t4_code", WW'(err_code), WW'(2'd2));
    chk("t4_state", WW'(dbg_state), WW'(3'd1));
    for (int i = 0; i < 12; i++) elem_mem[i] = 8'(8'h20 + i);
    send_frame(2, 3, 8'd0);
    chk("t4_done", WW'(frame_done), WW'(1'b1));
    idle(2);
    check_writes("t4_wr");

    // 5: full 32x32 random frame with trailing symbols
    for (int i = 0; i < NM * MD * MD; i++) elem_mem[i] = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    send_frame(32, 32, 8'd0);
    chk("t5_done", WW'(frame_done), WW'(1'b1));
    send_junk(16);
    chk("t5_busy_after", WW'(busy), WW'(1'b0));
    idle(2);
    check_writes("t5_wr");
    chk("t5_done_cnt", WW'(done_cnt - d0), WW'(1));
    chk("t5_dims", WW'({dim_rows, dim_cols}), WW'({8'd32, 8'd32}));

    // 6: reset mid-LOAD, released with axiiv high
    send_byte(8'd2);
    send_byte(8'd3);
    send_elem(8'h30);
    send_elem(8'h31);
    chk("t6_busy", WW'(busy), WW'(1'b1));
    rst = 1'b1;
    send_sym(2'b01);
    send_sym(2'b10);
    chk("t6_rst_outs", WW'({bus.wr_en, frame_done, frame_err, busy, err_code, dim_rows, dim_cols}), '0);
    chk("t6_rst_state", WW'(dbg_state), WW'(3'd0));
    rst = 1'b0;
    send_junk(16);
    chk("t6_ignored_state", WW'(dbg_state), WW'(3'd0));
    idle(2);
    check_writes("t6_nowr");
    for (int i = 0; i < 12; i++) elem_mem[i] = 8'(8'h40 + i);
    send_frame(2, 3, 8'd0);
    chk("t6_done", WW'(frame_done), WW'(1'b1));
    idle(2);
    check_writes("t6_wr");
    chk("t6_dims", WW'({dim_rows, dim_cols}), WW'({8'd2, 8'd3}));

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Parametrised dibit-stream matrix loader for the Ethernet receive path. Parses a framed stream of 2-bit symbols into a dimension header, NUM_MAT row-major matrices of up to MAX_DIM×MAX_DIM elements, and an optional checksum. Each completed row is emitted as one wide write to the downstream per-matrix row BRAMs. Frame status goes to the compute side via done and error pulses.

## Interface
Parameters:
- ELEM_W, 8: element width in bits; must be even, range 2..16.
- MAX_DIM, 32: maximum rows and cols; range 2..255.
- NUM_MAT, 2: matrices per frame; range 1..4.

Ports:
- eth_refclk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- axiiv  in  1  symbol valid; high for the whole frame.
- axiid  in  2  symbol data, MSB-first.
- wr_en  out  1  one-cycle row write strobe.
- wr_sel  out  max(1,$clog2(NUM_MAT))  target matrix index.
- wr_addr  out  $clog2(MAX_DIM)  row index within the matrix.
- wr_data  out  MAX_DIM*ELEM_W  row word; element j at [(MAX_DIM-j)*ELEM_W-1 -: ELEM_W]; slots j ≥ cols are zero.
- dim_rows, dim_cols  out  8 each  dimensions of the last accepted header.
- busy  out  1  high in HDR, LOAD and CHK.
- frame_done  out  1  one-cycle pulse when a frame completes cleanly.
- frame_err  out  1  one-cycle pulse when a frame fails.
- err_code  out  2  1 = bad header, 2 = truncated, 3 = checksum mismatch. Held until the next frame_err or frame_done (which clears it to 0).

## Operation
- Frame layout: rows byte (4 symbols), cols byte (4 symbols), then NUM_MAT × rows × cols elements of ELEM_W/2 symbols each, then (with CHECK_EN) one ELEM_W checksum.
- Matrices arrive in order 0..NUM_MAT-1; elements within a matrix are row-major.
- One symbol is consumed per cycle in which axiiv=1 and the state is HDR, LOAD or CHK.
- States and transitions:
  - WAIT: go to IDLE when axiiv=0.
  - IDLE: axiiv=1 consumes the first header symbol and moves to HDR.
  - HDR: after the 8th symbol, check rows and cols.
    - Either value 0 or > MAX_DIM: err_code=1, go to WAIT; dim_* are not updated.
    - Otherwise latch dim_* and go to LOAD.
  - LOAD: after the last symbol of the last element of matrix NUM_MAT-1, go to CHK (CHECK_EN) or finish cleanly.
  - CHK: after the final checksum symbol, compare and finish.
- Finishing a frame:
  - A clean finish pulses frame_done; a failed finish pulses frame_err.
  - Both then go to WAIT. Symbols after the end of a frame are ignored until axiiv drops.
- Truncation: axiiv=0 while in HDR, LOAD or CHK → frame_err with err_code=2, go directly to IDLE. Partial rows are never written.
- Counters:
  - Symbol index within an element, column, row and matrix.
  - Column wraps at dim_cols-1 and increments row. Row wraps at dim_rows-1 and increments matrix.
- Row buffer is cleared to zero at the start of every row, so unused upper slots are zero.
- Checksum: sum of all payload elements modulo 2^ELEM_W. Header bytes are excluded.
- Row writes precede checksum validation. Consumers must treat BRAM contents as valid only after frame_done.
- Reset: all outputs 0, dim_* = 0, state = WAIT. A stream already in flight when reset is released is discarded until axiiv drops.

## Timing
- wr_en, wr_sel, wr_addr and wr_data are registered.
- wr_en is high in the cycle after the edge that samples a row's last symbol. It is never high on consecutive cycles when ELEM_W/2·cols ≥ 2.
- frame_done / frame_err are high in the cycle after the edge that samples the final symbol (or the edge that sees the truncating axiiv=0).
- Without CHECK_EN, the last row's wr_en and frame_done coincide.
- An element is complete after ELEM_W/2 symbols. Minimum frame length is 8 + NUM_MAT·rows·cols·ELEM_W/2 symbols, plus ELEM_W/2 with CHECK_EN.
- A new frame may begin one cycle after axiiv=0 is seen in WAIT, or on the cycle after a truncation.

## Configuration
- Macro: MATRIX_STREAM_LOADER_CHECK_EN.
- Defined: CHK state, accumulator and compare are compiled in. The trailing checksum is required, and a mismatch gives err_code=3.
- Undefined: no CHK state and no accumulator. Frames end after the last payload element, and err_code 3 is never produced.

## Test plan
- ELEM_W=8, NUM_MAT=2, header 2/3, elements 0x01..0x0C, checksum 0x4E → 4 writes (sel0 addr0,1; sel1 addr0,1).
  - sel0 addr0 row = 0x010203 in the top 24 bits, remaining bits zero.
  - Then frame_done=1, err_code=0, dim_rows=2, dim_cols=3.
- Same frame with checksum 0x4F → identical 4 writes, then frame_err=1, err_code=3, no frame_done.
- Header rows=0 or cols=33 (MAX_DIM=32) → frame_err=1, err_code=1 after the 8th symbol.
  - No wr_en for the rest of the frame; dim_* unchanged.
  - The next valid frame after an axiiv gap loads normally.
- axiiv drops mid row 1 of matrix 0 → frame_err=1, err_code=2 next cycle, no write for row 1. A back-to-back frame one cycle later loads correctly.
- Full 32×32, NUM_MAT=2 random frame → 64 writes with wr_addr wrapping 31→0 and wr_sel 0→1, data matching the model. Extra trailing symbols are ignored.
- rst asserted mid-LOAD, released while axiiv=1 → all outputs 0, no writes until axiiv falls. The following frame loads correctly.
